gcd_driver: RTL and testbench

Initiator-side sequencer for the iterative GCD core. It accepts operand pairs on a valid/ready input stream and drives the core's `xi`/`yi`/`start`/`rst` pins. It waits for the core's `rdy`, captures `xo`, and returns the result on a valid/ready output stream with a timeout error flag. It sits between the system operand source and one GCD core instance, and owns that core's control pins exclusively.

---
 rtl/gcd_driver_if.sv | 24 ++
 rtl/gcd_driver.sv | 99 +++++++++
 tb/tb_gcd_driver.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/gcd_driver_if.sv
// Operand and result valid/ready streams between the system and gcd_driver.
// The slave modport is the driver's view; master is the operand source / result consumer.
interface gcd_driver_if #(
  parameter int unsigned NBits = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [NBits-1:0] in_x;
  logic [NBits-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [NBits-1:0] out_gcd;
  logic             out_err;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_gcd, out_err
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_gcd, out_err
  );
endinterface

// File: rtl/gcd_driver.sv
// Initiator-side sequencer for one iterative GCD core: loads operands, runs the core,
// captures its result (or aborts on timeout) and returns it on a valid/ready stream.
module gcd_driver #(
  parameter int unsigned NBits   = 8,
  parameter int unsigned TIMEOUT = 2 ** NBits + 8,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  gcd_driver_if.slave      bus,
  output logic [NBits-1:0] o_gcd_xi,
  output logic [NBits-1:0] o_gcd_yi,
  output logic             o_gcd_start,
  output logic             o_gcd_rst,
  input  logic [NBits-1:0] i_gcd_xo,
  input  logic             i_gcd_rdy
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StFlush, StDone} state_e;

  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

  state_e           r_state, w_state_nxt;
  logic [NBits-1:0] r_x, w_x;
  logic [NBits-1:0] r_y, w_y;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [NBits-1:0] r_gcd, w_gcd;
  logic             r_err, w_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_gcd   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x;
      r_y     <= w_y;
      r_cnt   <= w_cnt;
      r_gcd   <= w_gcd;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x         = r_x;
    w_y         = r_y;
    w_cnt       = r_cnt;
    w_gcd       = r_gcd;
    w_err       = r_err;
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_x         = bus.in_x;
          w_y         = bus.in_y;
          w_state_nxt = StLoad;
        end
      end
      StLoad: begin
        w_cnt       = '0;
        w_state_nxt = StRun;
      end
      StRun: begin
        w_cnt = r_cnt + CW'(1);
        // A ready core wins over a timeout landing on the same edge.
        if (i_gcd_rdy) begin
          w_gcd       = i_gcd_xo;
          w_err       = 1'b0;
          w_state_nxt = StDone;
        end else if (r_cnt == CntMax) begin
          w_gcd       = '0;
          w_err       = 1'b1;
          w_state_nxt = StFlush;
        end
      end
      StFlush: w_state_nxt = StDone;
      StDone: begin
        if (bus.out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // in_ready is gated by rst_n so nothing appears acceptable while reset is held.
  assign bus.in_ready  = i_rst_n & (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.out_gcd   = r_gcd;
  assign bus.out_err   = r_err;

  assign o_gcd_xi    = r_x;
  assign o_gcd_yi    = r_y;
  assign o_gcd_start = (r_state == StRun);
  assign o_gcd_rst   = ~i_rst_n | (r_state == StFlush);

endmodule

// File: tb/tb_gcd_driver.sv
// Directed bench for gcd_driver: one instance on a behavioural subtractive GCD core,
// one with TIMEOUT=16 on a core stub that never becomes ready.
module tb_gcd_driver;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  gcd_driver_if #(.NBits(8)) bus ();
  gcd_driver_if #(.NBits(8)) bus_t ();

  logic [7:0] gcd_xi, gcd_yi, gcd_xo;
  logic       gcd_start, gcd_rst, gcd_rdy;
  logic [7:0] t_xi, t_yi, t_xo;
  logic       t_start, t_rst, t_rdy;

  gcd_driver #(.NBits(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_gcd_xi    (gcd_xi),
    .o_gcd_yi    (gcd_yi),
    .o_gcd_start (gcd_start),
    .o_gcd_rst   (gcd_rst),
    .i_gcd_xo    (gcd_xo),
    .i_gcd_rdy   (gcd_rdy)
  );

  gcd_driver #(.NBits(8), .TIMEOUT(16)) dut_t (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus_t),
    .o_gcd_xi    (t_xi),
    .o_gcd_yi    (t_yi),
    .o_gcd_start (t_start),
    .o_gcd_rst   (t_rst),
    .i_gcd_xo    (t_xo),
    .i_gcd_rdy   (t_rdy)
  );

  // Core model: loads while start is low, one subtraction per cycle while running.
  logic [7:0] c_x, c_y;
  logic       c_rdy;
  always_ff @(posedge clk) begin
    if (gcd_rst) begin
      c_x   <= '0;
      c_y   <= '0;
      c_rdy <= 1'b0;
    end else if (!gcd_start) begin
      c_x   <= gcd_xi;
      c_y   <= gcd_yi;
      c_rdy <= 1'b0;
    end else if (!c_rdy) begin
      if (c_x == c_y || c_x == 8'd0 || c_y == 8'd0) c_rdy <= 1'b1;
      else if (c_x > c_y) c_x <= c_x - c_y;
      else c_y <= c_y - c_x;
    end
  end
  assign gcd_xo  = (c_x == 8'd0 || c_y == 8'd0) ? 8'd0 : c_x;
  assign gcd_rdy = c_rdy;

  assign t_xo  = 8'hAA;
  assign t_rdy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge with the driver idle; returns #1 after the accept edge.
  task automatic send(input bit sel, input logic [7:0] x, input logic [7:0] y);
    if (sel) begin
      check("t_in_ready_before_send", {31'd0, bus_t.in_ready}, 32'd1);
      bus_t.in_valid = 1'b1; bus_t.in_x = x; bus_t.in_y = y;
      @(posedge clk); #1;
      bus_t.in_valid = 1'b0;
    end else begin
      check("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1; bus.in_x = x; bus.in_y = y;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  // Cycles from accept until out_valid, plus start-high and core-reset-high samples seen.
  task automatic measure(input bit sel, output int lat, output int starts, output int rsts);
    lat = 0; starts = 0; rsts = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      lat++;
      starts += sel ? int'(t_start) : int'(gcd_start);
      rsts   += sel ? int'(t_rst) : int'(gcd_rst);
      if (sel ? bus_t.out_valid : bus.out_valid) break;
    end
  endtask

  task automatic handshake(input bit sel);
    if (sel) bus_t.out_ready = 1'b1; else bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus_t.out_ready = 1'b0;
    if (sel) check("t_idle_after_hs", {31'd0, bus_t.in_ready}, 32'd1);
    else check("idle_after_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
  endtask

  int  lat, starts, rsts;
  logic stall_ok;

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b0;
    bus_t.in_valid = 1'b0; bus_t.in_x = '0; bus_t.in_y = '0; bus_t.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_gcd_err", {23'd0, bus.out_gcd, bus.out_err}, 32'd0);
    check("rst_start_xi_yi", {15'd0, gcd_start, gcd_xi, gcd_yi}, 32'd0);
    check("rst_gcd_rst", {31'd0, gcd_rst}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("idle_gcd_rst", {31'd0, gcd_rst}, 32'd0);

    // (12,18): two subtractions
    send(1'b0, 8'd12, 8'd18);
    measure(1'b0, lat, starts, rsts);
    check("p12_18_lat", lat, 5);
    check("p12_18_starts", starts, 4);
    check("p12_18_gcd", {24'd0, bus.out_gcd}, 32'd6);
    check("p12_18_err", {31'd0, bus.out_err}, 32'd0);
    handshake(1'b0);

    // (9,9): best case
    send(1'b0, 8'd9, 8'd9);
    measure(1'b0, lat, starts, rsts);
    check("p9_9_lat", lat, 3);
    check("p9_9_gcd", {24'd0, bus.out_gcd}, 32'd9);
    handshake(1'b0);

    // (0,5): zero operand forwarded as 0
    send(1'b0, 8'd0, 8'd5);
    measure(1'b0, lat, starts, rsts);
    check("p0_5_lat", lat, 3);
    check("p0_5_gcd_err", {23'd0, bus.out_gcd, bus.out_err}, 32'd0);
    handshake(1'b0);

    // Timeout instance: core never ready
    send(1'b1, 8'd12, 8'd18);
    measure(1'b1, lat, starts, rsts);
    check("to_lat", lat, 18);
    check("to_err", {31'd0, bus_t.out_err}, 32'd1);
    check("to_gcd", {24'd0, bus_t.out_gcd}, 32'd0);
    check("to_rst_pulse", rsts, 1);
    check("to_starts", starts, 16);
    handshake(1'b1);

    // (21,14) with consumer stalled for 10 cycles
    send(1'b0, 8'd21, 8'd14);
    measure(1'b0, lat, starts, rsts);
    check("p21_14_lat", lat, 5);
    stall_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(bus.out_valid === 1'b1 && bus.out_gcd === 8'd7 && bus.in_ready === 1'b0 &&
            gcd_start === 1'b0)) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    check("p21_14_stall_hold", {31'd0, stall_ok}, 32'd1);
    check("p21_14_gcd", {24'd0, bus.out_gcd}, 32'd7);
    handshake(1'b0);
    send(1'b0, 8'd8, 8'd12);
    measure(1'b0, lat, starts, rsts);
    check("p8_12_gcd", {24'd0, bus.out_gcd}, 32'd4);
    check("p8_12_lat", lat, 5);
    handshake(1'b0);

    // Reset mid-RUN on (100,3)
    send(1'b0, 8'd100, 8'd3);
    repeat (5) @(posedge clk);
    #3;
    check("mid_run_start", {31'd0, gcd_start}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_outs", {28'd0, bus.out_valid, bus.in_ready, gcd_start, gcd_rst}, 32'd1);
    check("arst_xi_yi_gcd", {8'd0, gcd_xi, gcd_yi, bus.out_gcd}, 32'd0);
    bus.in_valid = 1'b1; bus.in_x = 8'd100; bus.in_y = 8'd3;
    repeat (2) @(posedge clk); #1;
    check("arst_held_no_valid", {30'd0, bus.out_valid, gcd_rst}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("accept_after_release", {30'd0, bus.in_ready, gcd_start}, 32'd0);
    measure(1'b0, lat, starts, rsts);
    check("p100_3_lat", lat, 38);
    check("p100_3_gcd", {24'd0, bus.out_gcd}, 32'd1);
    check("p100_3_err", {31'd0, bus.out_err}, 32'd0);
    handshake(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
